// File: rtl/aes_sbox_col_collect.sv
// Collects masked S-box columns into a 128-bit shared state word, adding the AES
// affine constant on share 0 and tracking S-box pipeline occupancy with credits.
module aes_sbox_col_collect #(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sb_issue,
    output logic               sb_ready,
    input  logic [32*d-1:0]    sb_out,
    output logic [128*d-1:0]   st_out,
    output logic               st_valid,
    input  logic               st_ready,
    output logic               err
);

    logic [2:0]          cnt_q, cnt_d;
    logic [1:0]          col_cnt_q, col_cnt_d;
    logic [LATENCY-1:0]  tag_q, tag_d;
    logic [128*d-1:0]    st_out_q, st_out_d;
    logic                st_valid_q, st_valid_d;
    logic                err_q, err_d;
    logic                accept_s, capture_s, handshake_s;
    logic [32*d-1:0]     col_s;

    // 0x63 placed on share 0 of every bit of every byte lane; other shares untouched.
    function automatic logic [32*d-1:0] affine_mask();
        logic [32*d-1:0] m;
        logic [7:0]      c;
        c = 8'h63;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
                m[(8*b+j)*d] = c[j];
            end
        end
        return m;
    endfunction

    assign sb_ready    = (cnt_q < 3'd4);
    assign accept_s    = sb_issue & sb_ready;
    assign capture_s   = tag_q[LATENCY-1];
    assign handshake_s = st_valid_q & st_ready;
    assign col_s       = sb_out ^ affine_mask();

    // Next-state logic for credits, tag delay line, column packing and status.
    always_comb begin
        tag_d      = '0;
        cnt_d      = cnt_q;
        col_cnt_d  = col_cnt_q;
        st_out_d   = st_out_q;
        st_valid_d = st_valid_q;
        err_d      = err_q | (sb_issue & ~sb_ready);

        tag_d[0] = accept_s;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // A handshake only happens at cnt=4, where no issue can be accepted.
        if (handshake_s) begin
            cnt_d = cnt_q - 3'd4;
        end else if (accept_s) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (capture_s) begin
            case (col_cnt_q)
                2'd0:    st_out_d[0*32*d +: 32*d] = col_s;
                2'd1:    st_out_d[1*32*d +: 32*d] = col_s;
                2'd2:    st_out_d[2*32*d +: 32*d] = col_s;
                2'd3:    st_out_d[3*32*d +: 32*d] = col_s;
                default: st_out_d = st_out_q;
            endcase
            col_cnt_d = col_cnt_q + 2'd1;
        end else begin
            col_cnt_d = col_cnt_q;
        end

        if (handshake_s) begin
            st_valid_d = 1'b0;
        end else if (capture_s && (col_cnt_q == 2'd3)) begin
            st_valid_d = 1'b1;
        end else begin
            st_valid_d = st_valid_q;
        end
    end

    // State registers; reset drops in-flight tags and partial columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 3'd0;
            col_cnt_q  <= 2'd0;
            tag_q      <= '0;
            st_out_q   <= '0;
            st_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            col_cnt_q  <= col_cnt_d;
            tag_q      <= tag_d;
            st_out_q   <= st_out_d;
            st_valid_q <= st_valid_d;
            err_q      <= err_d;
        end
    end

    assign st_out   = st_out_q;
    assign st_valid = st_valid_q;
    assign err      = err_q;

endmodule
